// File: rtl/eth_copy_packet_to_mem_if.sv
// RX-stream and reader-side signal bundle for eth_copy_packet_to_mem.
// The slave modport is the packet store; the master modport is its environment.
interface eth_copy_packet_to_mem_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pFIFO_WIDTH = 11,
  parameter int pDEPTH_RAM  = 2048
) ();
  localparam int CNT_W = $clog2(pDEPTH_RAM) + 1;

  logic                   idv;
  logic [pDATA_WIDTH-1:0] irx_d;
  logic                   irx_er;
  logic [2:0]             iframe_state;
  logic                   ird_en;
  logic                   oempty;
  logic                   ofull;
  logic [pDATA_WIDTH-1:0] or_data;
  logic [pFIFO_WIDTH-1:0] olen_pac;
  logic                   onext_last;
  logic [CNT_W-1:0]       obytes_to_read;
  logic                   ofifo_em;
  logic                   ofifo_full;

  modport slave (
    input  idv, irx_d, irx_er, iframe_state, ird_en,
    output oempty, ofull, or_data, olen_pac, onext_last, obytes_to_read, ofifo_em, ofifo_full
  );

  modport master (
    output idv, irx_d, irx_er, iframe_state, ird_en,
    input  oempty, ofull, or_data, olen_pac, onext_last, obytes_to_read, ofifo_em, ofifo_full
  );
endinterface

// File: rtl/eth_copy_packet_to_mem.sv
// Stores RX frames in a circular byte RAM; good frames are committed with their length queued
// in a FIFO, bad frames are rolled back. Define CPM_STRIP_FCS_EN to drop FCS bytes from storage.
module eth_copy_packet_to_mem #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMIN_PACKET_LENGHT = 64,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pFIFO_WIDTH        = 11,
  parameter int pDEPTH_RAM         = 2048,
  parameter int pFIFO_DEPTH        = 8
) (
  input logic                     iclk,
  input logic                     i_rst,
  eth_copy_packet_to_mem_if.slave bus
);
  localparam int AW  = $clog2(pDEPTH_RAM);
  localparam int PW  = AW + 1;
  localparam int FAW = $clog2(pFIFO_DEPTH);
  localparam int FPW = FAW + 1;

`ifdef CPM_STRIP_FCS_EN
  localparam int MIN_LEN = pMIN_PACKET_LENGHT - 4;
  localparam int MAX_LEN = pMAX_PACKET_LENGHT - 4;
`else
  localparam int MIN_LEN = pMIN_PACKET_LENGHT;
  localparam int MAX_LEN = pMAX_PACKET_LENGHT;
  localparam logic [2:0] FS_FCS = 3'd4;
`endif

  localparam logic [pFIFO_WIDTH-1:0] MIN_L = pFIFO_WIDTH'(MIN_LEN);
  localparam logic [pFIFO_WIDTH-1:0] MAX_L = pFIFO_WIDTH'(MAX_LEN);
  localparam logic [pFIFO_WIDTH-1:0] LEN_ONE = pFIFO_WIDTH'(1);
  localparam logic [PW-1:0]  PTR_ONE   = PW'(1);
  localparam logic [FPW-1:0] FPTR_ONE  = FPW'(1);
  localparam logic [2:0]     FS_DATA   = 3'd3;
  localparam logic [2:0]     FS_ERR    = 3'd5;

  localparam logic [1:0] S_WAIT  = 2'd0;
  localparam logic [1:0] S_STORE = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [pDATA_WIDTH-1:0] ram      [pDEPTH_RAM];
  logic [pFIFO_WIDTH-1:0] len_fifo [pFIFO_DEPTH];

  logic [1:0]             state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          c_ptr_q, c_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          btr_q, btr_d;
  logic [pFIFO_WIDTH-1:0] len_q, len_d;
  logic [pFIFO_WIDTH-1:0] done_q, done_d;
  logic [FPW-1:0]         fwr_q, fwr_d;
  logic [FPW-1:0]         frd_q, frd_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                   ram_we, push, pop, rd_accept;
  logic                   ram_full, fifo_em, fifo_full, take_byte, len_ok;
  logic [PW-1:0]          used;
  logic [pFIFO_WIDTH-1:0] head_len, remaining;

  // used counts uncommitted bytes too, so the writer only ever touches free space.
  assign used      = wr_ptr_q - rd_ptr_q;
  assign ram_full  = (used == PW'(pDEPTH_RAM));
  assign fifo_em   = (fwr_q == frd_q);
  assign fifo_full = ((fwr_q - frd_q) == FPW'(pFIFO_DEPTH));
  assign len_ok    = (len_q >= MIN_L) && (len_q <= MAX_L);
  assign head_len  = fifo_em ? '0 : len_fifo[frd_q[FAW-1:0]];
  assign remaining = head_len - done_q;
  assign rd_accept = bus.ird_en && (btr_q != '0);
  assign pop       = rd_accept && (remaining == LEN_ONE);

`ifdef CPM_STRIP_FCS_EN
  assign take_byte = bus.idv && (bus.iframe_state == FS_DATA);
`else
  assign take_byte = bus.idv && ((bus.iframe_state == FS_DATA) || (bus.iframe_state == FS_FCS));
`endif

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    c_ptr_d  = c_ptr_q;
    len_d    = len_q;
    ram_we   = 1'b0;
    push     = 1'b0;
    case (state_q)
      S_WAIT: begin
        len_d = '0;
        if (bus.idv && (bus.iframe_state == FS_DATA)) begin
          if (fifo_full || bus.irx_er || ram_full) begin
            state_d = S_DROP;
          end else begin
            ram_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = LEN_ONE;
            state_d  = S_STORE;
          end
        end
      end
      S_STORE: begin
        if (!bus.idv) begin
          state_d = S_WAIT;
          len_d   = '0;
          if (len_ok) begin
            push    = 1'b1;
            c_ptr_d = wr_ptr_q;
          end else begin
            wr_ptr_d = c_ptr_q;
          end
        end else if (bus.irx_er || (bus.iframe_state >= FS_ERR) ||
                     (take_byte && (ram_full || (len_q == MAX_L)))) begin
          state_d  = S_DROP;
          wr_ptr_d = c_ptr_q;
          len_d    = '0;
        end else if (take_byte) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          len_d    = len_q + LEN_ONE;
        end
      end
      S_DROP: begin
        if (!bus.idv) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  // Reader side: done_q counts bytes already taken from the head packet.
  always_comb begin
    rd_ptr_d = rd_accept ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rdata_d  = rd_accept ? ram[rd_ptr_q[AW-1:0]] : rdata_q;
    done_d   = pop ? '0 : (rd_accept ? done_q + LEN_ONE : done_q);
    fwr_d    = push ? fwr_q + FPTR_ONE : fwr_q;
    frd_d    = pop ? frd_q + FPTR_ONE : frd_q;
    btr_d    = btr_q + (push ? PW'(len_q) : '0) - (rd_accept ? PTR_ONE : '0);
  end

  // NOTE: the storage arrays have no reset; pointers alone define valid contents.
  always_ff @(posedge iclk) begin
    if (ram_we) ram[wr_ptr_q[AW-1:0]] <= bus.irx_d;
    if (push)   len_fifo[fwr_q[FAW-1:0]] <= len_q;
  end

  // NOTE: non-blocking assignments so all flops update together from pre-edge values.
  always_ff @(posedge iclk) begin
    if (i_rst) begin
      state_q  <= S_WAIT;
      wr_ptr_q <= '0;
      c_ptr_q  <= '0;
      rd_ptr_q <= '0;
      btr_q    <= '0;
      len_q    <= '0;
      done_q   <= '0;
      fwr_q    <= '0;
      frd_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      c_ptr_q  <= c_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      btr_q    <= btr_d;
      len_q    <= len_d;
      done_q   <= done_d;
      fwr_q    <= fwr_d;
      frd_q    <= frd_d;
      rdata_q  <= rdata_d;
    end
  end

  assign bus.oempty         = (btr_q == '0);
  assign bus.ofull          = ram_full;
  assign bus.or_data        = rdata_q;
  assign bus.olen_pac       = head_len;
  assign bus.onext_last     = !fifo_em && (remaining == LEN_ONE);
  assign bus.obytes_to_read = btr_q;
  assign bus.ofifo_em       = fifo_em;
  assign bus.ofifo_full     = fifo_full;
endmodule

// File: tb/tb_eth_copy_packet_to_mem.sv
// Scoreboard bench for eth_copy_packet_to_mem: expected bytes are queued when a good frame
// is sent and a monitor compares them against every accepted read.
module tb_eth_copy_packet_to_mem;
  logic iclk = 1'b0;
  logic i_rst;

  eth_copy_packet_to_mem_if bus ();

  eth_copy_packet_to_mem dut (
    .iclk  (iclk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    logic [7:0] data;
    bit         last;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  exp_t inflight;
  bit   pending = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   seed = 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  // Preamble, SFD, then n bytes (last 4 flagged as FCS); leaves idv=0 driven but not yet sampled.
  task automatic send_frame(input int n, input int err_at, input bit commit);
    logic [7:0] b;
    bus.idv = 1'b1; bus.irx_d = 8'h55; bus.iframe_state = 3'd1;
    tick(); tick();
    bus.irx_d = 8'hD5; bus.iframe_state = 3'd2;
    tick();
    for (int i = 0; i < n; i++) begin
      b = 8'(seed * 13 + i * 7 + 1);
      bus.irx_d        = b;
      bus.iframe_state = (i >= n - 4) ? 3'd4 : 3'd3;
      bus.irx_er       = (i == err_at);
      if (commit) exp_q.push_back('{data: b, last: (i == n - 1), len: n});
      tick();
    end
    bus.idv = 1'b0; bus.irx_er = 1'b0; bus.iframe_state = 3'd0;
    seed++;
  endtask

  task automatic slow_read(input int n, input int gap);
    repeat (n) begin
      bus.ird_en = 1'b1;
      tick();
      bus.ird_en = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic drain(input int max_cyc);
    int cyc = 0;
    bus.ird_en = 1'b1;
    while ((exp_q.size() != 0 || pending) && cyc < max_cyc) begin
      tick();
      cyc++;
    end
    bus.ird_en = 1'b0;
    if (cyc >= max_cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected after %0d cycles", exp_q.size(), cyc);
    end
    tick(); tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_oempty"},     bus.oempty, 1);
    check({tag, "_ofull"},      bus.ofull, 0);
    check({tag, "_or_data"},    bus.or_data, 0);
    check({tag, "_olen_pac"},   bus.olen_pac, 0);
    check({tag, "_onext_last"}, bus.onext_last, 0);
    check({tag, "_bytes"},      bus.obytes_to_read, 0);
    check({tag, "_fifo_em"},    bus.ofifo_em, 1);
    check({tag, "_fifo_full"},  bus.ofifo_full, 0);
  endtask

  // Monitor: a read accepted at a rising edge shows its byte before the following falling edge.
  always @(negedge iclk) begin
    if (pending) begin
      check("rd_data", bus.or_data, inflight.data);
      pending = 1'b0;
    end
    if (!i_rst && bus.ird_en && !bus.oempty) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_read: oempty=0 with obytes_to_read=%0d and no byte expected",
                 bus.obytes_to_read);
      end else begin
        inflight = exp_q.pop_front();
        check("onext_last", bus.onext_last, inflight.last);
        check("rd_olen_pac", bus.olen_pac, inflight.len);
        pending = 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.idv = 1'b0; bus.irx_d = '0; bus.irx_er = 1'b0; bus.iframe_state = 3'd0; bus.ird_en = 1'b0;
    i_rst = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    check_reset("rst");

    // Good minimum-size frame, no reads.
    send_frame(64, -1, 1);
    check("pre_commit_oempty", bus.oempty, 1);
    check("pre_commit_fifo_em", bus.ofifo_em, 1);
    tick();
    check("g64_olen_pac", bus.olen_pac, 64);
    check("g64_bytes", bus.obytes_to_read, 64);
    check("g64_fifo_em", bus.ofifo_em, 0);
    check("g64_oempty", bus.oempty, 0);
    check("g64_next_last", bus.onext_last, 0);
    drain(200);
    check("g64_done_oempty", bus.oempty, 1);
    check("g64_done_fifo_em", bus.ofifo_em, 1);
    check("g64_done_olen", bus.olen_pac, 0);
    check("g64_done_bytes", bus.obytes_to_read, 0);

    // Length boundaries: runt and oversize are dropped, maximum size commits.
    send_frame(63, -1, 0);
    tick();
    check("runt_bytes", bus.obytes_to_read, 0);
    check("runt_fifo_em", bus.ofifo_em, 1);
    send_frame(1537, -1, 0);
    tick();
    check("long_bytes", bus.obytes_to_read, 0);
    check("long_fifo_em", bus.ofifo_em, 1);
    send_frame(1536, -1, 1);
    tick();
    check("max_olen_pac", bus.olen_pac, 1536);
    check("max_bytes", bus.obytes_to_read, 1536);
    drain(1700);

    // RX error mid-frame, then a good frame of the same size.
    send_frame(100, 30, 0);
    tick();
    check("err_bytes", bus.obytes_to_read, 0);
    check("err_fifo_em", bus.ofifo_em, 1);
    send_frame(100, -1, 1);
    tick();
    check("g100_olen_pac", bus.olen_pac, 100);
    drain(200);

    // Nine frames without reads: the length FIFO holds eight.
    for (int f = 0; f < 9; f++) begin
      send_frame(64, -1, f < 8);
      tick();
      if (f == 7) check("fifo_full_at8", bus.ofifo_full, 1);
    end
    check("fifo9_bytes", bus.obytes_to_read, 512);
    check("fifo9_full", bus.ofifo_full, 1);
    check("fifo9_olen", bus.olen_pac, 64);
    drain(700);
    check("fifo9_drained_full", bus.ofifo_full, 0);

    // Fill the RAM exactly (wrapping past address 0), then overflow while reading slowly.
    send_frame(1000, -1, 1);
    tick();
    check("fill_a_bytes", bus.obytes_to_read, 1000);
    send_frame(984, -1, 1);
    tick();
    check("fill_b_bytes", bus.obytes_to_read, 1984);
    check("fill_b_ofull", bus.ofull, 0);
    send_frame(64, -1, 1);
    tick();
    check("fill_c_ofull", bus.ofull, 1);
    check("fill_c_bytes", bus.obytes_to_read, 2048);
    check("fill_c_olen", bus.olen_pac, 1000);
    fork
      begin send_frame(64, -1, 0); tick(); end
      slow_read(20, 3);
    join
    check("ovf_bytes", bus.obytes_to_read, 2028);
    check("ovf_ofull", bus.ofull, 0);
    check("ovf_olen", bus.olen_pac, 1000);
    drain(3000);
    check("ovf_done_bytes", bus.obytes_to_read, 0);
    check("ovf_done_oempty", bus.oempty, 1);

    // Reset with a committed frame pending and another frame in progress.
    send_frame(64, -1, 0);
    tick();
    check("pre_rst_bytes", bus.obytes_to_read, 64);
    bus.idv = 1'b1; bus.iframe_state = 3'd3;
    for (int i = 0; i < 20; i++) begin
      bus.irx_d = 8'(i);
      tick();
    end
    i_rst = 1'b1;
    tick();
    bus.idv = 1'b0; bus.iframe_state = 3'd0;
    tick();
    i_rst = 1'b0;
    tick();
    check_reset("mid_rst");

    // Commit while the reader is active.
    send_frame(64, -1, 1);
    tick();
    fork
      begin send_frame(64, -1, 1); tick(); end
      begin tick(); slow_read(34, 1); end
    join
    check("overlap_bytes", bus.obytes_to_read, 94);
    check("overlap_fifo_em", bus.ofifo_em, 0);
    check("overlap_olen", bus.olen_pac, 64);
    drain(300);
    check("overlap_done_bytes", bus.obytes_to_read, 0);
    check("exp_q_left", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/eth_copy_packet_to_mem.md
Name: eth_copy_packet_to_mem

Overview:
- Receive-side packet store that sits behind the Ethernet frame analyzer.
- Captures frame bytes from the 8-bit RX stream into a circular byte RAM, qualified by the analyzer's frame FSM state.
- At frame end, commits a good frame by pushing its length into a length FIFO; a bad frame is rolled back.
- A downstream reader pulls bytes with ird_en and receives the length and last-byte indications.

Parameters:
- pDATA_WIDTH, 8, RX and read data width.
- pMIN_PACKET_LENGHT, 64, minimum stored frame length in bytes (inclusive).
- pMAX_PACKET_LENGHT, 1536, maximum stored frame length in bytes (inclusive).
- pFIFO_WIDTH, 11, width of a length FIFO entry (equals olen_pac width).
- pDEPTH_RAM, 2048, byte RAM depth; must be a power of 2.
- pFIFO_DEPTH, 8, number of length FIFO entries, i.e. committed packets; must be a power of 2.

Ports:
- iclk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- idv  in  1  RX data valid.
- irx_d  in  8  RX byte.
- irx_er  in  1  RX error.
- iframe_state  in  3  analyzer FSM state: 0 IDLE, 1 PREAMBLE, 2 SFD, 3 DATA (DA through payload), 4 FCS, 5..7 ERROR.
- ird_en  in  1  read request for one byte.
- oempty  out  1  no committed bytes remain to read.
- ofull  out  1  byte RAM is full, counting uncommitted bytes.
- or_data  out  8  read byte, registered.
- olen_pac  out  11  length of the packet at the head of the FIFO; 0 when the FIFO is empty.
- onext_last  out  1  the next accepted read returns the last byte of the head packet.
- obytes_to_read  out  12  committed, unread bytes held in RAM.
- ofifo_em  out  1  length FIFO is empty.
- ofifo_full  out  1  length FIFO is full.

Behaviour:
- Reset values:
  - All pointers and counters are 0.
  - oempty=1, ofull=0, or_data=0, olen_pac=0, onext_last=0, obytes_to_read=0, ofifo_em=1, ofifo_full=0.
  - Any frame in progress is discarded.
- Write FSM has three states: WAIT, STORE, DROP.
- WAIT:
  - On idv=1 with iframe_state=3 (first DATA byte), go to STORE if ofifo_full=0. Otherwise go to DROP.
  - wr_ptr restarts from the committed pointer c_ptr; len=0.
- STORE:
  - Each cycle with idv=1 and iframe_state in {3,4}: write irx_d at wr_ptr, then increment wr_ptr (mod pDEPTH_RAM) and len.
  - Go to DROP, rolling wr_ptr back to c_ptr, on any of:
    - irx_er=1;
    - iframe_state>=5;
    - a write attempted while the RAM is full (used+1 > pDEPTH_RAM);
    - len would exceed pMAX_PACKET_LENGHT.
  - Frame end is idv falling (idv=0). At frame end:
    - If pMIN_PACKET_LENGHT <= len <= pMAX_PACKET_LENGHT, push len into the length FIFO, set c_ptr=wr_ptr, add len to obytes_to_read, then go to WAIT.
    - Otherwise roll back and go to WAIT.
- DROP:
  - Ignores bytes.
  - Returns to WAIT when idv=0.
- Commit visibility: the packet is visible to the reader (ofifo_em, olen_pac, obytes_to_read) in the cycle after the idv falling edge.
- Read side:
  - A read is accepted when ird_en=1 and oempty=0.
  - or_data is the RAM byte at rd_ptr, one-cycle latency after the accepted read.
  - Each accepted read increments rd_ptr and decrements obytes_to_read.
  - ird_en while oempty=1 is ignored; or_data holds its value.
  - A remaining-byte counter loads olen_pac when a new head packet appears.
  - onext_last = (ofifo_em=0) and (remaining==1), combinational.
  - An accepted read with remaining==1 pops the length FIFO; olen_pac shows the next entry on the following cycle.
- Simultaneous commit and read:
  - obytes_to_read gets +len-1 in the same cycle.
  - A FIFO push and pop in the same cycle leaves the entry count unchanged.
- Status outputs:
  - ofull = (wr_ptr - rd_ptr) == pDEPTH_RAM, counting uncommitted bytes.
  - oempty = (obytes_to_read==0).
- Wrap-around: all pointers and arithmetic are modulo pDEPTH_RAM; packets may straddle address 0.
- The reader is never stalled by the writer, because the write side only uses free space.

Optional Feature:
- Macro: CPM_STRIP_FCS_EN.
- When defined:
  - Bytes with iframe_state=4 are not stored.
  - Length checks are applied to DA..payload (pMIN_PACKET_LENGHT-4 .. pMAX_PACKET_LENGHT-4).
- When undefined: FCS bytes are stored and counted as specified above.

Test Plan:
- Good 64-byte frame (60 DATA + 4 FCS, no error), ird_en=0 -> one cycle after idv falls: olen_pac=64, obytes_to_read=64, ofifo_em=0, oempty=1->0.
- Then ird_en=1 continuously -> 64 bytes out in order, each byte one cycle after its read; onext_last=1 only before the 64th accepted read; afterwards oempty=1, ofifo_em=1, olen_pac=0.
- 63-byte runt and 1537-byte frame -> nothing committed; obytes_to_read stays 0, ofifo_em=1.
- irx_er=1 pulse on byte 30 of a 100-byte frame -> frame dropped; the following good 100-byte frame commits with olen_pac=100.
- Nine back-to-back 64-byte frames, no reads -> first 8 committed, ofifo_full=1, 9th dropped, obytes_to_read=512.
- Frames filling RAM past 2048 bytes with slow reads -> overflowing frame dropped, ofull asserted at used==2048, stored data intact across the address wrap; i_rst mid-frame -> all outputs return to reset values.
